calc_sequencer: RTL and testbench

- Command scheduler in front of the accumulator calculator datapath (8-bit accumulator; ops ADD/SUB/XOR/SHL with 3-bit operand; updates on the rising edge of its enable input).
- Two requesters share the datapath through a round-robin arbiter feeding a small command FIFO.
- An issue FSM drives the datapath's en/op/operand pins. Each en pulse is followed by a low gap, so the datapath's edge detector accepts exactly one operation per command.

---
 rtl/calc_pkg.sv | 23 ++
 rtl/calc_cmd_fifo.sv | 81 ++++++++
 rtl/calc_sequencer.sv | 125 ++++++++++++
 tb/tb_calc_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared encodings and the command record for the calculator command sequencer.
// The FIFO and the issue FSM both move commands around as calc_cmd_t.
package calc_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_SHL = 2'b11;

   localparam int CMD_W = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      DRIVE = 2'b01,
      GAP   = 2'b10
   } issue_state_e;

   typedef struct packed {
      logic [1:0] op;
      logic [2:0] operand;
   } calc_cmd_t;

endpackage

// File: rtl/calc_cmd_fifo.sv
// Small circular command FIFO: one push and one pop per cycle, synchronous flush.
// The occupancy counter is one bit wider than the pointers so that full and empty are unambiguous.
module calc_cmd_fifo
   import calc_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clock,
   input  logic      reset,
   input  logic      push,
   input  calc_cmd_t push_data,
   input  logic      pop,
   input  logic      flush,
   output calc_cmd_t head,
   output logic      full,
   output logic      empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   calc_cmd_t     mem_q [DEPTH];
   calc_cmd_t     mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push_s, do_pop_s;

   assign full      = (count_q == FULL_CNT);
   assign empty     = (count_q == '0);
   assign head      = mem_q[rd_ptr_q];
   assign do_push_s = push && !flush && !full;
   assign do_pop_s  = pop && !flush && !empty;

   // Flush wins over a same-cycle push or pop; pointers wrap naturally at DEPTH.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/calc_sequencer.sv
// Round-robin command scheduler in front of the accumulator datapath.
// Two requesters feed a command FIFO; an issue FSM emits one en pulse per command with a gap after it.
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic [1:0]       req0_op,
   input  logic [2:0]       req0_operand,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [1:0]       req1_op,
   input  logic [2:0]       req1_operand,
   output logic             req1_ready,
   input  logic             flush,
   output logic             calc_en,
   output logic [1:0]       calc_op,
   output logic [2:0]       calc_in,
   output logic             busy,
   output logic [CNT_W-1:0] issued_count
);

   issue_state_e     state_q, state_d;
   logic             rr_ptr_q, rr_ptr_d;
   logic             calc_en_q, calc_en_d;
   logic [1:0]       calc_op_q, calc_op_d;
   logic [2:0]       calc_in_q, calc_in_d;
   logic [CNT_W-1:0] issued_count_q, issued_count_d;
   logic             grant0_s, grant1_s, push_s, pop_s;
   logic             fifo_full_s, fifo_empty_s;
   calc_cmd_t        push_cmd_s, head_s;

   calc_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push_s),
      .push_data (push_cmd_s),
      .pop       (pop_s),
      .flush     (flush),
      .head      (head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s)
   );

   // Arbiter: rr_ptr_q low favours req0; full is the registered state, so no push-through-pop.
   always_comb begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
      rr_ptr_d = rr_ptr_q;
      if (!flush && !fifo_full_s) begin
         if (req0_valid && (!req1_valid || !rr_ptr_q)) begin
            grant0_s = 1'b1;
            rr_ptr_d = 1'b1;
         end else if (req1_valid) begin
            grant1_s = 1'b1;
            rr_ptr_d = 1'b0;
         end else begin
            rr_ptr_d = rr_ptr_q;
         end
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
      push_s             = grant0_s || grant1_s;
      push_cmd_s.op      = grant1_s ? req1_op : req0_op;
      push_cmd_s.operand = grant1_s ? req1_operand : req0_operand;
   end

   // Issue FSM: a pop only happens outside DRIVE, which guarantees the low gap after each pulse.
   always_comb begin
      state_d        = state_q;
      pop_s          = 1'b0;
      calc_op_d      = calc_op_q;
      calc_in_d      = calc_in_q;
      issued_count_d = issued_count_q;
      case (state_q)
         IDLE, GAP: begin
            if (!fifo_empty_s && !flush) begin
               pop_s     = 1'b1;
               calc_op_d = head_s.op;
               calc_in_d = head_s.operand;
               state_d   = DRIVE;
            end else begin
               state_d = IDLE;
            end
         end
         DRIVE: begin
            issued_count_d = issued_count_q + 1'b1;
            state_d        = GAP;
         end
         default: state_d = IDLE;
      endcase
      calc_en_d = (state_d == DRIVE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         rr_ptr_q       <= 1'b0;
         calc_en_q      <= 1'b0;
         calc_op_q      <= 2'b00;
         calc_in_q      <= 3'b000;
         issued_count_q <= '0;
      end else begin
         state_q        <= state_d;
         rr_ptr_q       <= rr_ptr_d;
         calc_en_q      <= calc_en_d;
         calc_op_q      <= calc_op_d;
         calc_in_q      <= calc_in_d;
         issued_count_q <= issued_count_d;
      end
   end

   assign req0_ready   = grant0_s;
   assign req1_ready   = grant1_s;
   assign calc_en      = calc_en_q;
   assign calc_op      = calc_op_q;
   assign calc_in      = calc_in_q;
   assign issued_count = issued_count_q;
   assign busy         = !fifo_empty_s || (state_q != IDLE);

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: queue-based reference model checked every cycle,
// a table of single commands, directed multi-cycle corner cases and a randomized phase.
module tb_calc_sequencer;
   import calc_pkg::*;

   localparam int DEPTH = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       req0_valid, req1_valid, req0_ready, req1_ready;
   logic [1:0] req0_op, req1_op, calc_op;
   logic [2:0] req0_operand, req1_operand, calc_in;
   logic       flush, calc_en, busy;
   logic [7:0] issued_count;

   always #5 clock = ~clock;

   calc_sequencer #(.DEPTH(DEPTH), .CNT_W(8)) dut (
      .clock        (clock),
      .reset        (reset),
      .req0_valid   (req0_valid),
      .req0_op      (req0_op),
      .req0_operand (req0_operand),
      .req0_ready   (req0_ready),
      .req1_valid   (req1_valid),
      .req1_op      (req1_op),
      .req1_operand (req1_operand),
      .req1_ready   (req1_ready),
      .flush        (flush),
      .calc_en      (calc_en),
      .calc_op      (calc_op),
      .calc_in      (calc_in),
      .busy         (busy),
      .issued_count (issued_count)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: pending commands as op*8+operand, the command being driven, and pulse phase.
   int mq[$];
   bit m_ptr, m_en, m_gap;
   int m_op, m_in, m_count;

   // Emulated datapath and observation logs.
   int dp_acc;
   int en_log[$];
   int acc_log[$];
   int en_cyc[$];
   int cyc, accepted, issued_total;
   bit s_r0, s_r1, s_en, s_busy;

   typedef struct {
      int sel;
      int op;
      int opd;
      int exp_acc;
   } vec_t;
   vec_t tbl[8];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int apply_op(input int acc, input int op, input int v);
      case (op)
         0:       return (acc + v) & 255;
         1:       return (acc - v) & 255;
         2:       return (acc ^ v) & 255;
         default: return (acc << v) & 255;
      endcase
   endfunction

   task automatic model_reset();
      mq.delete();
      m_ptr   = 1'b0;
      m_en    = 1'b0;
      m_gap   = 1'b0;
      m_op    = 0;
      m_in    = 0;
      m_count = 0;
   endtask

   task automatic idle_inputs();
      req0_valid = 1'b0; req0_op = 2'b00; req0_operand = 3'b000;
      req1_valid = 1'b0; req1_op = 2'b00; req1_operand = 3'b000;
      flush      = 1'b0;
   endtask

   task automatic set_req(input int sel, input bit v, input int op, input int opd);
      if (sel == 0) begin
         req0_valid = v; req0_op = 2'(op); req0_operand = 3'(opd);
      end else begin
         req1_valid = v; req1_op = 2'(op); req1_operand = 3'(opd);
      end
   endtask

   // Entered at posedge+1; asserts reset, checks reset values, releases at the next posedge+1.
   task automatic do_reset();
      idle_inputs();
      reset = 1'b0;
      model_reset();
      #1;
      check("rst_calc_en", int'(calc_en), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_calc_op", int'(calc_op), 0);
      check("rst_calc_in", int'(calc_in), 0);
      check("rst_count", int'(issued_count), 0);
      @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   // One clock cycle: compare every output against the model mid-cycle, then advance the model.
   task automatic step();
      bit full, r0, r1, busy_e, pop_ok;
      int pv0, pv1;
      #3;
      full   = (mq.size() == DEPTH);
      r0     = !flush && !full && req0_valid && (!req1_valid || !m_ptr);
      r1     = !flush && !full && req1_valid && !r0;
      busy_e = (mq.size() != 0) || m_en || m_gap;
      check("req0_ready", int'(req0_ready), int'(r0));
      check("req1_ready", int'(req1_ready), int'(r1));
      check("calc_en", int'(calc_en), int'(m_en));
      check("calc_op", int'(calc_op), m_op);
      check("calc_in", int'(calc_in), m_in);
      check("busy", int'(busy), int'(busy_e));
      check("issued_count", int'(issued_count), m_count);
      s_r0   = req0_ready;
      s_r1   = req1_ready;
      s_en   = calc_en;
      s_busy = busy;
      if (calc_en) begin
         dp_acc = apply_op(dp_acc, int'(calc_op), int'(calc_in));
         en_log.push_back(int'(calc_op) * 8 + int'(calc_in));
         acc_log.push_back(dp_acc);
         en_cyc.push_back(cyc);
         issued_total++;
      end
      if (req0_valid && req0_ready) accepted++;
      if (req1_valid && req1_ready) accepted++;
      pv0 = int'(req0_op) * 8 + int'(req0_operand);
      pv1 = int'(req1_op) * 8 + int'(req1_operand);
      pop_ok = !flush && (mq.size() != 0) && !m_en;
      @(posedge clock);
      if (m_en) m_count = (m_count + 1) % 256;
      if (pop_ok) begin
         m_op = mq[0] / 8;
         m_in = mq[0] % 8;
      end
      if (flush) begin
         mq.delete();
      end else begin
         if (pop_ok) void'(mq.pop_front());
         if (r0) mq.push_back(pv0);
         if (r1) mq.push_back(pv1);
      end
      if (r0) m_ptr = 1'b1;
      else if (r1) m_ptr = 1'b0;
      m_gap = m_en;
      m_en  = pop_ok;
      cyc++;
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int first, pulses, g, cnt0, bound, last_en, first_idle;
      bit seen255;
      tbl[0] = '{0, 0, 5, 5};
      tbl[1] = '{1, 1, 2, 3};
      tbl[2] = '{0, 2, 6, 5};
      tbl[3] = '{1, 3, 2, 20};
      tbl[4] = '{0, 3, 7, 0};
      tbl[5] = '{1, 1, 1, 255};
      tbl[6] = '{0, 0, 7, 6};
      tbl[7] = '{1, 2, 3, 5};
      cyc = 0; accepted = 0; issued_total = 0;

      do_reset();
      dp_acc = 0;

      // Single commands: en exactly once, two cycles after acceptance, datapath result as tabulated.
      for (int i = 0; i < 8; i++) begin
         set_req(tbl[i].sel, 1'b1, tbl[i].op, tbl[i].opd);
         step();
         check("tbl_ready", int'(tbl[i].sel == 0 ? s_r0 : s_r1), 1);
         set_req(tbl[i].sel, 1'b0, 0, 0);
         first = -1; pulses = 0;
         for (int c = 1; c <= 5; c++) begin
            step();
            if (s_en) begin
               pulses++;
               if (first < 0) first = c;
               check("tbl_op", en_log[en_log.size() - 1], tbl[i].op * 8 + tbl[i].opd);
            end
         end
         check("tbl_pulses", pulses, 1);
         check("tbl_latency", first, 2);
         check("tbl_acc", dp_acc, tbl[i].exp_acc);
         check("tbl_count", int'(issued_count), i + 1);
      end

      // Contention: both requesters continuously for 4 cycles.
      do_reset();
      dp_acc = 0; en_log.delete();
      for (int c = 0; c < 4; c++) begin
         set_req(0, 1'b1, 0, 1);
         set_req(1, 1'b1, 1, 1);
         step();
         g = s_r0 ? 0 : (s_r1 ? 1 : -1);
         check("cont_grant", g, c % 2);
      end
      idle_inputs();
      for (int c = 0; c < 12; c++) step();
      check("cont_pulses", en_log.size(), 4);
      for (int k = 0; k < 4 && k < en_log.size(); k++) begin
         check("cont_order", en_log[k], (k % 2 == 0) ? 1 : 9);
      end
      check("cont_acc", dp_acc, 0);
      check("cont_count", int'(issued_count), 4);

      // Back-to-back: XOR 7, SHL 1, ADD 3, SUB 2 from accumulator 0.
      do_reset();
      dp_acc = 0; en_log.delete(); acc_log.delete(); en_cyc.delete();
      set_req(0, 1'b1, 2, 7); step();
      set_req(0, 1'b1, 3, 1); step();
      set_req(0, 1'b1, 0, 3); step();
      set_req(0, 1'b1, 1, 2); step();
      idle_inputs();
      first_idle = -1;
      for (int c = 0; c < 12; c++) begin
         step();
         if (!s_busy && first_idle < 0 && en_cyc.size() == 4) first_idle = cyc - 1;
      end
      check("b2b_pulses", en_cyc.size(), 4);
      if (en_cyc.size() == 4) begin
         for (int k = 1; k < 4; k++) check("b2b_spacing", en_cyc[k] - en_cyc[k - 1], 2);
         check("b2b_acc0", acc_log[0], 7);
         check("b2b_acc1", acc_log[1], 14);
         check("b2b_acc2", acc_log[2], 17);
         check("b2b_acc3", acc_log[3], 15);
         last_en = en_cyc[3];
         check("b2b_busy_fall", first_idle, last_en + 2);
      end

      // Full boundary: FIFO full while the FSM pops; req1 must wait exactly one cycle.
      do_reset();
      accepted = 0;
      bound = 0;
      while (!(mq.size() == DEPTH && !m_en && m_gap) && bound < 40) begin
         set_req(0, 1'b1, bound % 4, bound % 8);
         step();
         bound++;
      end
      check("full_reached", int'(bound < 40), 1);
      set_req(0, 1'b0, 0, 0);
      set_req(1, 1'b1, 0, 1);
      step();
      check("full_r1_blocked", int'(s_r1), 0);
      step();
      check("full_r1_next", int'(s_r1), 1);
      idle_inputs();
      for (int c = 0; c < 20; c++) step();
      check("full_no_loss", int'(issued_count), accepted);
      check("full_drained", int'(busy), 0);

      // Flush during a DRIVE with two commands still queued behind it.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         set_req(0, 1'b1, 2, k + 1);
         step();
      end
      idle_inputs();
      bound = 0;
      while (!(m_en && mq.size() == 2) && bound < 20) begin
         step();
         bound++;
      end
      check("flush_reached", int'(bound < 20), 1);
      cnt0 = int'(issued_count);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_inflight_done", int'(issued_count), cnt0 + 1);
      check("flush_gap_en", int'(calc_en), 0);
      check("flush_gap_busy", int'(busy), 1);
      step();
      check("flush_idle_busy", int'(busy), 0);
      pulses = 0;
      for (int c = 0; c < 5; c++) begin
         step();
         if (s_en) pulses++;
      end
      check("flush_discarded", pulses, 0);
      check("flush_count_final", int'(issued_count), cnt0 + 1);

      // Reset asserted in the middle of a DRIVE cycle.
      set_req(0, 1'b1, 0, 3);
      step();
      idle_inputs();
      bound = 0;
      while (!m_en && bound < 10) begin
         step();
         bound++;
      end
      check("rstmid_en_before", int'(calc_en), 1);
      #2;
      do_reset();

      // Count wrap: 256 random commands from both requesters.
      accepted = 0; issued_total = 0; seen255 = 1'b0;
      bound = 0;
      while (issued_total < 256 && bound < 3000) begin
         if (accepted < 256) begin
            set_req(0, ($urandom_range(0, 1) == 1), $urandom_range(0, 3), $urandom_range(0, 7));
            set_req(1, ($urandom_range(0, 1) == 1), $urandom_range(0, 3), $urandom_range(0, 7));
         end else begin
            idle_inputs();
         end
         step();
         if (int'(issued_count) == 255) seen255 = 1'b1;
         bound++;
      end
      idle_inputs();
      check("wrap_reached", int'(bound < 3000), 1);
      check("wrap_total", issued_total, 256);
      check("wrap_seen255", int'(seen255), 1);
      check("wrap_zero", int'(issued_count), 0);

      // Randomized traffic with occasional flushes, model-checked every cycle.
      for (int c = 0; c < 300; c++) begin
         set_req(0, ($urandom_range(0, 2) != 0), $urandom_range(0, 3), $urandom_range(0, 7));
         set_req(1, ($urandom_range(0, 2) != 0), $urandom_range(0, 3), $urandom_range(0, 7));
         flush = ($urandom_range(0, 15) == 0);
         step();
      end
      idle_inputs();
      for (int c = 0; c < 20; c++) step();
      check("rand_drained", int'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
